// File: rtl/counter_datacheck.sv
// counter_datacheck: receive-side checker for the incrementing counter pattern
// that counter_datagen drives through the HPIO TX lanes. It finds byte alignment
// by rotating received words, locks to the counter sequence, and then counts
// checked words and mismatches for loopback link qualification.
//
// Optional feature macro: DATACHECK_BITSLIP_EN
//   defined   - rotation search; a VERIFY mismatch advances rot_sel.
//   undefined - rot_sel is tied to 0 and no rotation logic is built.
//
// Ports:
//   clk          in   CLK_200M system clock
//   reset        in   synchronous, active-high reset
//   data_valid   in   data_in holds a valid received word this cycle
//   data_in      in   received word from the RX FIFO
//   clear_stats  in   single-cycle pulse, zeroes err_count and word_count
//   locked       out  high while in LOCKED
//   rot_sel      out  rotate-right amount applied to received words
//   err_pulse    out  one-cycle pulse on each mismatch while LOCKED
//   err_count    out  saturating mismatch count while LOCKED
//   word_count   out  saturating count of words checked while LOCKED
module counter_datacheck #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_valid,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          clear_stats,
    output logic                          locked,
    output logic [$clog2(DATA_WIDTH)-1:0] rot_sel,
    output logic                          err_pulse,
    output logic [CNT_WIDTH-1:0]          err_count,
    output logic [CNT_WIDTH-1:0]          word_count
);

    localparam int unsigned RotW = $clog2(DATA_WIDTH);
    localparam int unsigned McW  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int unsigned EcW  = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] d1_q;
    logic                  v1_q;
    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic [McW-1:0]        match_cnt_q, match_cnt_d;
    logic [EcW-1:0]        consec_err_q, consec_err_d;
    logic                  locked_q, locked_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic [DATA_WIDTH-1:0] r;

`ifdef DATACHECK_BITSLIP_EN
    logic [RotW-1:0]         rot_sel_q, rot_sel_d;
    logic [2*DATA_WIDTH-1:0] rot_dbl;

    // Rotate right: shifting a doubled copy keeps the wrapped-around bits.
    always_comb begin
        rot_dbl = {d1_q, d1_q} >> rot_sel_q;
        r       = rot_dbl[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rot_sel_q <= '0;
        end else begin
            rot_sel_q <= rot_sel_d;
        end
    end

    always_comb begin
        rot_sel_d = rot_sel_q;
        if (v1_q && (state_q == StVerify) && (r != expected_q)) begin
            rot_sel_d = rot_sel_q + RotW'(1);
        end
    end

    assign rot_sel = rot_sel_q;
`else
    assign r       = d1_q;
    assign rot_sel = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_q         <= '0;
            v1_q         <= 1'b0;
            state_q      <= StSearch;
            expected_q   <= '0;
            match_cnt_q  <= '0;
            consec_err_q <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            d1_q         <= data_in;
            v1_q         <= data_valid;
            state_q      <= state_d;
            expected_q   <= expected_d;
            match_cnt_q  <= match_cnt_d;
            consec_err_q <= consec_err_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        match_cnt_d  = match_cnt_q;
        consec_err_d = consec_err_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;

        if (v1_q) begin
            unique case (state_q)
                StSearch: begin
                    expected_d  = r + DATA_WIDTH'(1);
                    match_cnt_d = '0;
                    state_d     = StVerify;
                end
                StVerify: begin
                    if (r == expected_q) begin
                        expected_d  = r + DATA_WIDTH'(1);
                        match_cnt_d = match_cnt_q + McW'(1);
                        if (match_cnt_q == McW'(LOCK_COUNT - 1)) begin
                            state_d      = StLocked;
                            consec_err_d = '0;
                        end
                    end else begin
                        state_d = StSearch;
                    end
                end
                StLocked: begin
                    // Expected free-runs so a single corrupted word costs one error.
                    expected_d = expected_q + DATA_WIDTH'(1);
                    if (word_count_q != '1) begin
                        word_count_d = word_count_q + CNT_WIDTH'(1);
                    end
                    if (r == expected_q) begin
                        consec_err_d = '0;
                    end else begin
                        err_pulse_d  = 1'b1;
                        consec_err_d = consec_err_q + EcW'(1);
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_WIDTH'(1);
                        end
                        if (consec_err_q == EcW'(UNLOCK_ERRS - 1)) begin
                            state_d = StSearch;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        // Clearing wins over a same-cycle increment; err_pulse is unaffected.
        if (clear_stats) begin
            err_count_d  = '0;
            word_count_d = '0;
        end

        locked_d = (state_d == StLocked);
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;

endmodule
